sm4_key_schedule: RTL and testbench

- Iterative SM4 key-expansion controller sitting directly upstream of the cipher datapath.
- Accepts a 128-bit master key via valid/ready handshake and XORs it with the FK constants.
- Runs one key-expansion round per clock for 32 clocks, generating CK on the fly; each round is the standard SM4 round (tau S-box, L' = x ^ x<<<13 ^ x<<<23) instantiated once inside.
- Stores rk0..rk31 in an internal register file, streams each key as produced, and exposes a registered random-access read port for the encrypt/decrypt rounds.

---
 rtl/sm4_key_schedule.sv | 108 ++++++++++
 tb/tb_sm4_key_schedule.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_schedule.sv
// Iterative SM4 key expansion: one round per clock, 32 round keys stored in a
// register file, streamed as produced, and readable through a registered port.
module sm4_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] mkey,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  output logic         rk_stream_valid,
  output logic [4:0]   rk_stream_idx,
  output logic [31:0]  rk_stream_data,
  input  logic [4:0]   rk_raddr,
  output logic [31:0]  rk_rdata
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[11'd2047 - {x, 3'b000} -: 8];
  endfunction

  state_t        state, next_state;
  logic [4:0]    cnt;
  logic [127:0]  k;
  logic [31:0]   rk_mem [32];
  logic          accept;
  logic [7:0]    ck_base;
  logic [31:0]   ck, t_in, t_sub, t_lin, new_rk;

  assign key_ready = (state != EXPAND);
  assign busy      = (state == EXPAND);
  assign accept    = key_valid && key_ready;

  // CK byte j of round i is 7*(4i+j) mod 256; the modulo falls out of 8-bit arithmetic.
  always_comb begin
    ck_base = 8'({1'b0, cnt, 2'b00}) * 8'd7;
    ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
  end

  always_comb begin
    t_in   = k[95:64] ^ k[63:32] ^ k[31:0] ^ ck;
    t_sub  = {sbox(t_in[31:24]), sbox(t_in[23:16]), sbox(t_in[15:8]), sbox(t_in[7:0])};
    t_lin  = t_sub ^ {t_sub[18:0], t_sub[31:19]} ^ {t_sub[8:0], t_sub[31:9]};
    new_rk = k[127:96] ^ t_lin;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE: if (accept) next_state = EXPAND;
      EXPAND:     if (cnt == 5'd31) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values; this also gives read-before-write on rk_rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      k               <= '0;
      keys_valid      <= 1'b0;
      rk_stream_valid <= 1'b0;
      rk_stream_idx   <= '0;
      rk_stream_data  <= '0;
      rk_rdata        <= '0;
    end else begin
      state           <= next_state;
      rk_rdata        <= rk_mem[rk_raddr];
      rk_stream_valid <= 1'b0;
      if (state == EXPAND) begin
        k               <= {k[95:0], new_rk};
        cnt             <= cnt + 5'd1;
        rk_stream_valid <= 1'b1;
        rk_stream_idx   <= cnt;
        rk_stream_data  <= new_rk;
        if (cnt == 5'd31) keys_valid <= 1'b1;
      end else if (accept) begin
        k          <= mkey ^ FK;
        cnt        <= '0;
        keys_valid <= 1'b0;
      end
    end
  end

  // NOTE: the key memory is deliberately not reset; a fresh expansion rewrites
  // every entry, and leaving reset off lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (!rst && state == EXPAND) rk_mem[cnt] <= new_rk;
  end

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Directed bench for sm4_key_schedule: table of master keys with golden round
// keys, plus hand sequences for rekey, ignored requests, reset abort and back-to-back.
module tb_sm4_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] mkey;
  logic         key_valid;
  logic         key_ready, busy, keys_valid, rk_stream_valid;
  logic [4:0]   rk_stream_idx, rk_raddr;
  logic [31:0]  rk_stream_data, rk_rdata;

  sm4_key_schedule dut (
    .clk(clk), .rst(rst), .mkey(mkey), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
    .rk_stream_valid(rk_stream_valid), .rk_stream_idx(rk_stream_idx),
    .rk_stream_data(rk_stream_data), .rk_raddr(rk_raddr), .rk_rdata(rk_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] mkey;
    logic [31:0]  rk0;
    logic [31:0]  rk31;
    bit           from_model;
  } vec_t;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;

  int           n_vec = 0;
  int           n_err = 0;
  logic [2047:0] sbox_bits;
  logic [31:0]  last_rk [32];
  bit           last_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_tprime(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) begin
      int idx;
      idx = int'(x[31-8*j -: 8]);
      b[31-8*j -: 8] = sbox_bits[2047-8*idx -: 8];
    end
    return b ^ ((b << 13) | (b >> 19)) ^ ((b << 23) | (b >> 9));
  endfunction

  task automatic model_expand(input logic [127:0] mk, output logic [31:0] rk [32]);
    logic [31:0] kk [36];
    logic [31:0] fk [4];
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int j = 0; j < 4; j++) kk[j] = mk[127-32*j -: 32] ^ fk[j];
    for (int i = 0; i < 32; i++) begin
      logic [31:0] ck;
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      kk[i+4] = kk[i] ^ m_tprime(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
      rk[i]   = kk[i+4];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " key_ready"}, 32'(key_ready), 32'd1);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " keys_valid"}, 32'(keys_valid), 32'd0);
    check({tag, " stream_valid"}, 32'(rk_stream_valid), 32'd0);
    check({tag, " stream_idx"}, 32'(rk_stream_idx), 32'd0);
    check({tag, " stream_data"}, rk_stream_data, 32'd0);
    check({tag, " rk_rdata"}, rk_rdata, 32'd0);
  endtask

  // Accept mk, follow all 32 rounds, then read back rk0 and rk31.
  task automatic do_set(input logic [127:0] mk, input logic [31:0] exp [32],
                        input int inject_at, input int abort_at, input bit ck_probe);
    @(negedge clk);
    check("key_ready before accept", 32'(key_ready), 32'd1);
    mkey      = mk;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    check("keys_valid after accept", 32'(keys_valid), 32'd0);
    check("busy after accept", 32'(busy), 32'd1);
    check("stream_valid after accept", 32'(rk_stream_valid), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (ck_probe && i == 0)  check("ck round 0", dut.ck, 32'h00070E15);
      if (ck_probe && i == 1)  check("ck round 1", dut.ck, 32'h1C232A31);
      if (ck_probe && i == 31) check("ck round 31", dut.ck, 32'h646B7279);
      if (i == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("abort");
        return;
      end
      if (i == inject_at) begin
        key_valid = 1'b1;
        mkey      = ~mk;
        check("key_ready while busy", 32'(key_ready), 32'd0);
      end
      if (i == 5) rk_raddr = 5'd5;
      @(negedge clk);
      key_valid = 1'b0;
      mkey      = mk;
      check($sformatf("stream_valid[%0d]", i), 32'(rk_stream_valid), 32'd1);
      check($sformatf("stream_idx[%0d]", i), 32'(rk_stream_idx), 32'(i));
      check($sformatf("stream_data[%0d]", i), rk_stream_data, exp[i]);
      check($sformatf("keys_valid[%0d]", i), 32'(keys_valid), 32'(i == 31));
      check($sformatf("busy[%0d]", i), 32'(busy), 32'(i != 31));
      if (i == 5 && last_valid) check("read-before-write rk5", rk_rdata, last_rk[5]);
      if (i == 6) check("read after write rk5", rk_rdata, exp[5]);
    end
    rk_raddr = 5'd0;
    @(negedge clk);
    check("rk_rdata[0]", rk_rdata, exp[0]);
    check("stream_valid in DONE", 32'(rk_stream_valid), 32'd0);
    rk_raddr = 5'd31;
    @(negedge clk);
    check("rk_rdata[31]", rk_rdata, exp[31]);
    check("keys_valid held in DONE", 32'(keys_valid), 32'd1);
    check("key_ready in DONE", 32'(key_ready), 32'd1);
    last_rk    = exp;
    last_valid = 1'b1;
  endtask

  initial begin
    vec_t        vecs [3];
    logic [31:0] exp [32];
    logic [31:0] exp_std [32];
    logic [31:0] exp_b [32];
    logic [127:0] key_b;

    sbox_bits = {
      128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
      128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
      128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
      128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
      128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
      128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
      128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
      128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    vecs[0] = '{STD_KEY, 32'hF12186F9, 32'h9124A012, 1'b0};
    vecs[1] = '{128'h0, 32'h0, 32'h0, 1'b1};
    vecs[2] = '{{128{1'b1}}, 32'h0, 32'h0, 1'b1};

    rst       = 1'b1;
    key_valid = 1'b0;
    mkey      = '0;
    rk_raddr  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Table: standard key, then rekey from DONE with all-zero and all-one keys.
    for (int v = 0; v < 3; v++) begin
      model_expand(vecs[v].mkey, exp);
      if (!vecs[v].from_model) begin
        exp[0]  = vecs[v].rk0;
        exp[31] = vecs[v].rk31;
      end
      if (v == 0) exp_std = exp;
      do_set(vecs[v].mkey, exp, -1, -1, v == 0);
    end

    // Request with a different key during the 10th expansion cycle is ignored.
    do_set(STD_KEY, exp_std, 9, -1, 1'b0);

    // Reset at round 15, then the standard key again from scratch.
    do_set(STD_KEY, exp_std, -1, 15, 1'b0);
    do_set(STD_KEY, exp_std, -1, -1, 1'b1);

    // key_valid held high: second key accepted in the single DONE cycle.
    key_b = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    model_expand(key_b, exp_b);
    @(negedge clk);
    mkey      = STD_KEY;
    key_valid = 1'b1;
    @(negedge clk);
    mkey = key_b;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (c <= 32) begin
        check($sformatf("b2b A stream_valid[%0d]", c), 32'(rk_stream_valid), 32'd1);
        check($sformatf("b2b A stream_data[%0d]", c), rk_stream_data, exp_std[c-1]);
      end else if (c == 33) begin
        check("b2b gap stream_valid", 32'(rk_stream_valid), 32'd0);
        check("b2b gap keys_valid", 32'(keys_valid), 32'd0);
        check("b2b gap busy", 32'(busy), 32'd1);
      end else begin
        check($sformatf("b2b B stream_valid[%0d]", c), 32'(rk_stream_valid), 32'd1);
        check($sformatf("b2b B stream_idx[%0d]", c), 32'(rk_stream_idx), 32'(c - 34));
        check($sformatf("b2b B stream_data[%0d]", c), rk_stream_data, exp_b[c-34]);
      end
      if (c == 32 || c == 65) check($sformatf("b2b keys_valid[%0d]", c), 32'(keys_valid), 32'd1);
    end
    key_valid = 1'b0;
    @(negedge clk);
    check("b2b final stream_valid", 32'(rk_stream_valid), 32'd0);
    check("b2b final keys_valid", 32'(keys_valid), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
